// File: rtl/fir_pkg.sv
// Shared constants for the 3-tap FIR: widths, default taps, saturation limits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

  localparam int NUM_TAPS = 3;
  localparam int DATA_W   = 8;
  localparam int OUT_W    = 11;
  localparam int ACC_W    = 18;

  // Reset-time coefficient set, c0 first.
  localparam logic signed [DATA_W-1:0] COEFF_DEFAULT [NUM_TAPS] = '{8'sd1, 8'sd2, 8'sd1};

  // Output clamp limits, expressed at accumulator width so compares are width-matched.
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  // Default for tap i; taps beyond the default table come up as zero.
  function automatic int coeff_default(input int i);
    if (i >= 0 && i < NUM_TAPS) begin
      return int'(COEFF_DEFAULT[i]);
    end
    return 0;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient registers with a write pointer that steps through taps while load is held.
// Latency: a write is visible on the coeffs output one clock after the loading edge.
// Backpressure: none; every edge with load=1 consumes one coefficient.
module fir_coeff_bank #(
  parameter int NUM_TAPS = fir_pkg::NUM_TAPS,
  parameter int DATA_W   = fir_pkg::DATA_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic [DATA_W-1:0]                  din,
  output logic [NUM_TAPS-1:0][DATA_W-1:0]    coeffs
);
  import fir_pkg::coeff_default;

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TAPS - 1);

  logic [IDX_W-1:0] idx;

  // Load burst: write the current tap, wrap after the last one; idx restarts whenever load drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        coeffs[i] <= DATA_W'(coeff_default(i));
      end
    end else if (load) begin
      coeffs[idx] <= din;
      idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      idx <= '0;
    end
  end

endmodule

// File: rtl/fir_main.sv
// Direct-form FIR: c0*x + c1*d0 + c2*d1, full-precision sum clamped to the output range.
// Latency: one clock from a valid sample to its c0 contribution on o_y_n.
// Backpressure: none; tvalid=0 freezes history and output, coefficient load wins over tvalid.
module fir_main #(
  parameter int NUM_TAPS = fir_pkg::NUM_TAPS,
  parameter int DATA_W   = fir_pkg::DATA_W,
  parameter int OUT_W    = fir_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_n,
  input  logic                     s_axis_fir_tvalid,
  input  logic                     s_set_coeffs,
  output logic signed [OUT_W-1:0]  o_y_n
);
  import fir_pkg::*;

  localparam int PROD_W = 2 * DATA_W;

  logic [NUM_TAPS-1:0][DATA_W-1:0] coeffs;
  logic [NUM_TAPS-2:0][DATA_W-1:0] dly;
  logic signed [ACC_W-1:0]         acc;
  logic signed [OUT_W-1:0]         y_sat;
  logic                            take_sample;

  // One signed product, sign-extended to accumulator width.
  function automatic logic signed [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] c,
                                                        input logic [DATA_W-1:0] s);
    logic signed [PROD_W-1:0] p;
    p = $signed(c) * $signed(s);
    return ACC_W'(p);
  endfunction

  fir_coeff_bank #(
    .NUM_TAPS (NUM_TAPS),
    .DATA_W   (DATA_W)
  ) u_coeff_bank (
    .clk    (clk),
    .reset  (reset),
    .load   (s_set_coeffs),
    .din    (x_n),
    .coeffs (coeffs)
  );

  assign take_sample = s_axis_fir_tvalid && !s_set_coeffs;

  // Multiply-accumulate over the current sample and the history, then clamp.
  always_comb begin
    acc = mac_term(coeffs[0], x_n);
    for (int i = 1; i < NUM_TAPS; i++) begin
      acc = acc + mac_term(coeffs[i], dly[i-1]);
    end
    if (acc > OUT_MAX) begin
      y_sat = OUT_W'(OUT_MAX);
    end else if (acc < OUT_MIN) begin
      y_sat = OUT_W'(OUT_MIN);
    end else begin
      y_sat = acc[OUT_W-1:0];
    end
  end

  // Register the result and shift history only on an accepted sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_y_n <= '0;
      dly   <= '0;
    end else if (take_sample) begin
      o_y_n  <= y_sat;
      dly[0] <= x_n;
      for (int i = 1; i < NUM_TAPS - 1; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fir_main.sv
// Self-checking bench for fir_main: vector table plus reset corner sequences.
// Latency: expects each result one clock after the driving edge.
// Backpressure: exercises tvalid stalls and load-over-sample priority.
module tb_fir_main;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [7:0]  x_n;
  logic               s_axis_fir_tvalid;
  logic               s_set_coeffs;
  logic signed [10:0] o_y_n;

  typedef struct {
    logic              set;
    logic              vld;
    logic signed [7:0] x;
    logic signed [10:0] yexp;
  } vec_t;

  vec_t               tbl[$];
  logic signed [10:0] sb[$];
  int                 n_vec = 0;
  int                 n_bad = 0;

  fir_main dut (
    .clk               (clk),
    .reset             (reset),
    .x_n               (x_n),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .s_set_coeffs      (s_set_coeffs),
    .o_y_n             (o_y_n)
  );

  always #5 clk = ~clk;

  function automatic void add(input int set, input int vld, input int x, input int y);
    vec_t v;
    v.set  = set[0];
    v.vld  = vld[0];
    v.x    = 8'(x);
    v.yexp = 11'(y);
    tbl.push_back(v);
  endfunction

  // Pop the oldest expectation and compare against the output now.
  task automatic compare(input string name);
    logic signed [10:0] e;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, o_y_n=%0d", name, o_y_n);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (o_y_n !== e) begin
        n_bad++;
        $display("FAIL %s: o_y_n=%0d expected %0d", name, o_y_n, e);
      end
    end
  endtask

  task automatic step(input logic set, input logic vld, input logic signed [7:0] x,
                      input logic signed [10:0] y, input string name);
    @(negedge clk);
    s_set_coeffs      = set;
    s_axis_fir_tvalid = vld;
    x_n               = x;
    sb.push_back(y);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic check_now(input logic signed [10:0] y, input string name);
    sb.push_back(y);
    compare(name);
  endtask

  initial begin
    reset             = 1'b0;
    x_n               = '0;
    s_axis_fir_tvalid = 1'b0;
    s_set_coeffs      = 1'b0;

    // Default impulse 1,2,1
    add(0,1,1,1); add(0,1,0,2); add(0,1,0,1); add(0,1,0,0);
    // Idle holds
    add(0,0,9,0);
    // Load 1,2,3, output held
    add(1,0,1,0); add(1,0,2,0); add(1,0,3,0);
    // Impulse with stalls
    add(0,1,1,1); add(0,0,55,1); add(0,1,0,2); add(0,0,0,2); add(0,1,0,3); add(0,1,0,0);
    // Priority: load with tvalid high, 4 writes wrap to c0 -> 9,6,7
    add(0,1,1,1);
    add(1,1,5,1); add(1,1,6,1); add(1,1,7,1); add(1,1,9,1);
    add(0,1,0,6); add(0,1,0,7); add(0,1,0,0);
    // Broken burst restarts at c0 -> 3,6,7
    add(1,0,4,0); add(0,0,0,0); add(1,0,3,0);
    add(0,1,1,3); add(0,1,0,6); add(0,1,0,7); add(0,1,0,0);
    // 127,127,127: just below the clamp, then saturation both ways
    add(1,0,127,0); add(1,0,127,0); add(1,0,127,0);
    add(0,1,8,1016); add(0,1,0,1016); add(0,1,0,1016); add(0,1,0,0);
    add(0,1,-8,-1016); add(0,1,-8,-1024);
    add(0,1,127,1023); add(0,1,127,1023); add(0,1,127,1023);
    add(0,1,-128,1023); add(0,1,-128,-1024); add(0,1,-128,-1024);
    // c0=-128: exact lower limit and +1024 clamps to 1023
    add(1,0,-128,-1024); add(1,0,0,-1024); add(1,0,0,-1024);
    add(0,1,8,-1024); add(0,1,-8,1023); add(0,1,0,0);

    #1;
    check_now(11'sd0, "reset_out");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].set, tbl[i].vld, tbl[i].x, tbl[i].yexp, $sformatf("vec%0d", i));
    end

    // Build history and a half-finished load, then reset asynchronously
    step(1'b0, 1'b1, 8'sd5, -11'sd640, "pre_rst_sample");
    step(1'b1, 1'b0, 8'sd7, -11'sd640, "pre_rst_load0");
    step(1'b1, 1'b0, 8'sd7, -11'sd640, "pre_rst_load1");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_now(11'sd0, "async_reset");
    s_set_coeffs = 1'b0;
    @(posedge clk);
    #1;
    check_now(11'sd0, "reset_held");
    @(negedge clk);
    reset = 1'b1;

    // Defaults and cleared history after release
    step(1'b0, 1'b1, 8'sd1, 11'sd1, "restore0");
    step(1'b0, 1'b1, 8'sd0, 11'sd2, "restore1");
    step(1'b0, 1'b1, 8'sd0, 11'sd1, "restore2");
    step(1'b0, 1'b1, 8'sd0, 11'sd0, "restore3");

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_main.md
FIR_MAIN -- requirements
Module: fir_main

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, asynchronous, active-low; low clears state immediately, release is synchronous to `clk`.
REQ-003 The block SHALL have the port `x_n`: input, 8 bits, signed two's-complement; it carries a sample when `s_axis_fir_tvalid`=1 and a coefficient when `s_set_coeffs`=1.
REQ-004 The block SHALL have the port `s_axis_fir_tvalid`: input, 1 bit, sample-valid qualifier.
REQ-005 The block SHALL have the port `s_set_coeffs`: input, 1 bit, coefficient-load mode.
REQ-006 The block SHALL have the port `o_y_n`: output, 11 bits, signed, registered filter result.
REQ-007 The block SHALL have the parameter NUM_TAPS, default 3, number of taps (and coefficients).
REQ-008 The block SHALL have the parameter DATA_W, default 8, sample and coefficient width.
REQ-009 The block SHALL have the parameter OUT_W, default 11, output width.

Function
REQ-010 The block SHALL hold coefficients c0..c2 as signed 8-bit registers, with defaults c0=1, c1=2, c2=1.
REQ-011 The block SHALL hold a delay line d0..d1 of signed 8-bit past samples.
REQ-012 On an edge with `s_set_coeffs`=1, the block SHALL write c[idx] <= `x_n` and advance idx 0->1->2->0 (wrap); the delay line and `o_y_n` hold.
REQ-013 idx SHALL return to 0 on any edge with `s_set_coeffs`=0, so every load burst starts at c0.
REQ-014 `s_set_coeffs` SHALL take priority over `s_axis_fir_tvalid` when both are 1; the load occurs and no sample is processed.
REQ-015 On an edge with `s_set_coeffs`=0 and `s_axis_fir_tvalid`=1, the block SHALL update o_y_n <= sat(c0*`x_n` + c1*d0 + c2*d1), then d0 <= `x_n` and d1 <= d0.
REQ-016 On an edge with both inputs 0, all state SHALL hold.
REQ-017 Latency: a sample presented before edge k SHALL contribute c0·x at `o_y_n` after edge k, c1·x after the next valid edge, and c2·x after the one following.
REQ-018 Arithmetic: products SHALL be 16-bit signed and the sum an 18-bit signed full-precision value.
REQ-019 Saturation: the output SHALL clamp to [-1024, +1023]; there is no wrap and no rounding.
REQ-020 A coefficient change SHALL affect only results computed on edges after the write.

Reset
REQ-021 While `reset`=0, the block SHALL set o_y_n=0, d0=d1=0, idx=0, and c0..c2 to defaults 1,2,1.
REQ-022 Reset SHALL discard any loaded coefficients and an in-progress load burst.
REQ-023 The first valid edge after release SHALL compute using defaults and an all-zero history.

Structure
REQ-024 The shared package `fir_pkg` SHALL contain NUM_TAPS, DATA_W, OUT_W, ACC_W=18, the default coefficient array, and the OUT_MAX/OUT_MIN saturation constants.
REQ-025 There SHALL be one sub-module, `fir_coeff_bank`, holding the coefficient registers, idx counter, wrap logic and reset defaults.
REQ-026 The delay line, MAC and saturation SHALL be implemented in fir_main itself.

Verification
REQ-027 Default impulse: after reset, tvalid=1, x_n=0 except a single 1 -> `o_y_n` 1, 2, 1 on successive edges, then 0.
REQ-028 Coefficient load: s_set_coeffs=1 for 3 edges with x_n=1,2,3, then an impulse -> `o_y_n` 1, 2, 3, then 0; output is held during the load.
REQ-029 Reset restore: after the REQ-028 case, pulse reset low and apply an impulse -> `o_y_n` 1, 2, 1.
REQ-030 Step and saturation: load coefficients 127,127,127 and apply x_n=127 steadily -> `o_y_n` 1023, with no wrap; with x_n=-128 -> -1024.
REQ-031 Stall and priority: tvalid=0 mid-impulse -> `o_y_n` and history freeze and resume on return; 4 load edges with 5,6,7,9 -> c0=9, c1=6, c2=7.
REQ-032 Async reset: assert reset low between clock edges -> `o_y_n`=0 immediately, without waiting for an edge.
